// File: rtl/conv_mac_3x3.sv
// conv_mac_3x3: streaming 3x3 convolution multiply-accumulate with valid/ready handshakes
// vedic_2x2:    2x2 Vedic multiplier cell        a, b -> p
// vedic_4x4:    4x4 Vedic multiplier from 2x2    a, b -> p
// conv_mac_3x3: clk, rst (sync, active high)
//               in_valid/in_ready/pix/wgt        pixel/weight pair input
//               out_valid/out_ready/out_sum      completed window sum output
module vedic_2x2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic c;
  logic h;
  assign c = a[1] & b[0] & a[0] & b[1];
  assign h = a[1] & b[1];
  assign p = {h & c, h ^ c, (a[1] & b[0]) ^ (a[0] & b[1]), a[0] & b[0]};
endmodule

module vedic_4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [3:0] q0, q1, q2, q3;
  vedic_2x2 u0 (.a(a[1:0]), .b(b[1:0]), .p(q0));
  vedic_2x2 u1 (.a(a[3:2]), .b(b[1:0]), .p(q1));
  vedic_2x2 u2 (.a(a[1:0]), .b(b[3:2]), .p(q2));
  vedic_2x2 u3 (.a(a[3:2]), .b(b[3:2]), .p(q3));
  assign p = {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
endmodule

module conv_mac_3x3 #(
  parameter int TAPS  = 9,
  parameter int SUM_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       pix,
  input  logic [3:0]       wgt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum
);
  localparam int CW = TAPS > 1 ? $clog2(TAPS) : 1;
  logic [CW-1:0]    tap_cnt;
  logic [7:0]       prod, prod_q;
  logic             prod_v, first_q, last_q, accept;
  logic [SUM_W-1:0] acc, sum;
  vedic_4x4 u_mul (.a(pix), .b(wgt), .p(prod));
  assign in_ready = !out_valid;
  assign accept   = in_valid && in_ready;
  // the first tap restarts the window so no separate clear cycle is needed
  assign sum      = first_q ? SUM_W'(prod_q) : acc + SUM_W'(prod_q);
  always_ff @(posedge clk) begin
    if (rst) begin
      tap_cnt   <= '0;
      prod_q    <= '0;
      prod_v    <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      acc       <= '0;
      out_sum   <= '0;
      out_valid <= 1'b0;
    end else begin
      prod_v <= accept;
      if (accept) begin
        tap_cnt <= tap_cnt == CW'(TAPS - 1) ? '0 : tap_cnt + 1'b1;
        prod_q  <= prod;
        first_q <= tap_cnt == '0;
        last_q  <= tap_cnt == CW'(TAPS - 1);
      end
      if (prod_v) acc <= sum;
      if (prod_v && last_q) begin
        out_sum   <= sum;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_conv_mac_3x3.sv
// tb_conv_mac_3x3: scoreboard bench for conv_mac_3x3 with a window-sum reference model
module tb_conv_mac_3x3;
  localparam int TAPS = 9;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid;
  logic [3:0] pix = 0, wgt = 0;
  logic [11:0] out_sum;
  int tests = 0, fails = 0, cyc = 0;
  int taps[$];
  int exp_q[$];
  int lat_q[$];
  logic ov_prev = 0;

  conv_mac_3x3 #(.TAPS(TAPS), .SUM_W(12)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pix(pix), .wgt(wgt),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // model: every TAPS accepted pairs form one window whose sum is the plain sum of products
  always @(negedge clk) begin
    if (rst) begin
      taps.delete();
      lat_q.delete();
    end else begin
      if (out_valid && !ov_prev) begin
        chk("valid_expected", int'(lat_q.size() > 0), 1);
        if (lat_q.size() > 0) chk("latency", cyc - lat_q.pop_front(), 2);
      end
      if (out_valid && out_ready) begin
        chk("sum_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("out_sum", int'(out_sum), exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        taps.push_back(int'(pix) * int'(wgt));
        if (taps.size() == TAPS) begin
          exp_q.push_back(taps.sum());
          lat_q.push_back(cyc);
          taps.delete();
        end
      end
    end
    ov_prev = out_valid;
  end

  task automatic send(input int p, input int w);
    in_valid = 1;
    pix = 4'(p);
    wgt = 4'(w);
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1 in_valid = 0;
        return;
      end
    end
    chk("accept_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hi, pos;
    idle(2);
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sum", int'(out_sum), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(posedge clk) #1 rst = 0;

    for (int i = 0; i < TAPS; i++) send(15, 15);
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      hi += int'(out_valid);
    end
    chk("valid_cycles", hi, 1);
    idle(1);

    for (int k = 1; k <= TAPS; k++) send(k, 1);
    for (int i = 0; i < TAPS; i++) send(2, 3);
    idle(4);

    out_ready = 0;
    fork
      for (int i = 0; i < 2 * TAPS; i++) send(15, 15);
      begin
        for (int t = 0; t < 100 && !out_valid; t++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge clk);
          chk("hold_valid", int'(out_valid), 1);
          chk("hold_sum", int'(out_sum), 2025);
          chk("hold_in_ready", int'(in_ready), 0);
        end
        @(posedge clk) #1 out_ready = 1;
      end
    join
    idle(4);

    for (int i = 0; i < 3 * TAPS; i++) begin
      send(1, 1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(4);

    for (int i = 0; i < 5; i++) send(3, 4);
    rst = 1;
    @(posedge clk) #1 rst = 0;
    @(negedge clk);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_sum", int'(out_sum), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    for (int i = 0; i < TAPS; i++) send(1, 1);
    idle(4);

    for (int w = 0; w < 4; w++)
      for (int i = 0; i < TAPS; i++) begin
        send($urandom_range(0, 15), $urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) idle(1);
      end
    idle(4);

    for (int p = 0; p < 16; p++)
      for (int w = 0; w < 16; w++) begin
        pos = $urandom_range(0, TAPS - 1);
        for (int t = 0; t < TAPS; t++) send(t == pos ? p : 0, t == pos ? w : 0);
      end

    for (int t = 0; t < 100 && exp_q.size() > 0; t++) @(negedge clk);
    chk("drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
